poco_dmem: RTL and testbench
============================

Name: poco_dmem

Overview:
- Data-memory responder for the POCO 16-bit core's data port. The core is the initiator on daddr/ddataout/we; this block is the responder and returns ddatain.
- Contains a word-addressed RAM plus a small memory-mapped I/O page: output port, synchronised input port, and a prescaled timer with a compare flag.
- Reads are combinational, because the core completes a load in one cycle. Writes take effect on the clock edge.

Parameters:
- DATA_W, 16, data and address width (matches the core's DATA_W).
- RAM_AW, 8, RAM address bits; RAM occupies words 0 .. 2**RAM_AW-1.
- PRESC, 4, timer increments once every PRESC enabled cycles; legal range 1..256.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- daddr  in  DATA_W  word address from the core.
- ddataout  in  DATA_W  write data from the core.
- we  in  1  write strobe from the core, sampled on the rising edge of clk.
- ddatain  out  DATA_W  read data to the core, combinational from daddr.
- out_port  out  DATA_W  OUT register value.
- in_port  in  DATA_W  asynchronous external input.
- tmr_irq  out  1  level copy of STATUS.flag.

Behaviour:
- Address decode:
  - RAM: daddr < 2**RAM_AW.
  - 0xFFF0: OUT, read/write.
  - 0xFFF1: IN, read-only.
  - 0xFFF2: CNT, read/write.
  - 0xFFF3: CMP, read/write.
  - 0xFFF4: STATUS. bit0 flag (write-1-to-clear), bit1 en (read/write), bits 15:2 read 0.
  - Any other address reads 0x0000; writes to it are ignored.
- Reads:
  - ddatain is a pure function of daddr and current state, with no clock latency.
  - A read in the same cycle as a write to that address returns the old value.
- Writes:
  - When we=1 at the rising edge of clk, the addressed location takes ddataout.
  - Writes to IN are ignored.
- RAM:
  - Not reset; contents are X until written.
  - One write port, one asynchronous read port.
- Reset:
  - out_port=0, CNT=0, CMP=0xFFFF, flag=0, en=0, prescaler=0, both in_port sync stages=0, tmr_irq=0.
  - Asserting rst mid-count clears all of the above immediately. RAM is untouched.
- IN: in_port passes through a two-flop synchroniser. A change on in_port is visible at 0xFFF1 after the second rising edge.
- Timer, when en=1:
  - The prescaler counts 0..PRESC-1.
  - A tick occurs on the edge where the prescaler equals PRESC-1; the prescaler then wraps to 0.
  - On a tick: if CNT==CMP, then CNT<=0 and flag<=1. Otherwise CNT<=CNT+1 (mod 2**16).
- Timer, when en=0: prescaler and CNT hold their values.
- Collisions and clearing:
  - A core write to CNT in the same cycle as a tick: the write wins, and the prescaler restarts at 0.
  - Writing CMP does not touch CNT or the prescaler.
  - W1C to flag in the same cycle as a match: set wins, so flag stays 1.
  - Writing bit0=0 to STATUS leaves flag unchanged. bit1 is written directly.
- tmr_irq equals flag and is registered, not combinational from CNT.

Decomposition:
- Shared package / def.h additions:
  - Address constants: `IO_OUT`, `IO_IN`, `IO_CNT`, `IO_CMP`, `IO_STAT`.
  - STATUS bit positions: `ST_FLAG`=0, `ST_EN`=1.
  - Reuse `DATA_W`.
- One natural sub-module: poco_timer, holding the prescaler, CNT, CMP, flag and en, with a write-enable/select interface. The RAM and decode stay in poco_dmem.

Test Plan:
1. Reset, then read 0xFFF0, 0xFFF2, 0xFFF3, 0xFFF4, 0x1234 -> ddatain reads 0x0000, 0x0000, 0xFFFF, 0x0000, 0x0000; tmr_irq=0.
2. RAM: write 0xBEEF to 0x0005 and 0x1111 to 0x00FF, then read both -> same-cycle combinational read returns 0xBEEF and 0x1111. A read of 0x0005 in the write cycle returns the old value. Writing 0x0100 does not alias to RAM word 0.
3. Output/input ports:
   - Write 0xA5A5 to 0xFFF0 -> out_port=0xA5A5 after the edge.
   - Drive in_port=0x0F0F -> 0xFFF1 reads 0x0F0F starting from the second edge, and the previous value before that.
4. Timer, PRESC=4: write CMP=3, then STATUS=0x0002 -> CNT reads 1, 2, 3 every 4 cycles. The flag is set and CNT=0 on the 16th enabled cycle, and tmr_irq=1.
5. Flag collisions:
   - Write STATUS=0x0003 -> flag clears and en stays 1.
   - Write STATUS=0x0003 on the exact cycle of the next match -> flag stays 1.
   - Write CNT=0x0002 on a tick cycle -> CNT=2 and the prescaler restarts.
6. Wrap and mid-count reset:
   - Set CMP=0xFFFF and CNT=0xFFFE, enable -> CNT reaches 0xFFFF, then 0 with flag=1.
   - Pulse rst mid-count -> CNT=0, en=0, out_port=0 immediately; RAM word 0x0005 still reads 0xBEEF.

Source files
------------

// File: rtl/poco_dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : poco_dmem_pkg
// Description : Shared constants, I/O page map and address decode for poco_dmem
// Revision    : 1.0  initial release
// ============================================================================
package poco_dmem_pkg;

  localparam int DATA_W = 16;

  localparam logic [DATA_W-1:0] IO_OUT  = 16'hFFF0;
  localparam logic [DATA_W-1:0] IO_IN   = 16'hFFF1;
  localparam logic [DATA_W-1:0] IO_CNT  = 16'hFFF2;
  localparam logic [DATA_W-1:0] IO_CMP  = 16'hFFF3;
  localparam logic [DATA_W-1:0] IO_STAT = 16'hFFF4;

  localparam int ST_FLAG = 0;
  localparam int ST_EN   = 1;

  typedef enum logic [2:0] {
    SEL_NONE = 3'd0,
    SEL_RAM  = 3'd1,
    SEL_OUT  = 3'd2,
    SEL_IN   = 3'd3,
    SEL_CNT  = 3'd4,
    SEL_CMP  = 3'd5,
    SEL_STAT = 3'd6
  } io_sel_e;

  // RAM wins over the I/O page only when the address fits in RAM_AW bits.
  function automatic io_sel_e decode(input logic [DATA_W-1:0] addr, input int unsigned ram_aw);
    io_sel_e sel;
    sel = SEL_NONE;
    if ((addr >> ram_aw) == '0) begin
      sel = SEL_RAM;
    end else begin
      case (addr)
        IO_OUT:  sel = SEL_OUT;
        IO_IN:   sel = SEL_IN;
        IO_CNT:  sel = SEL_CNT;
        IO_CMP:  sel = SEL_CMP;
        IO_STAT: sel = SEL_STAT;
        default: sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/poco_timer.sv
`default_nettype none
// ============================================================================
// Module      : poco_timer
// Description : Prescaled up-counter with compare match flag and STATUS register
// Revision    : 1.0  initial release
// ============================================================================
module poco_timer
  import poco_dmem_pkg::*;
#(
  parameter int PRESC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  io_sel_e           i_sel,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_cnt,
  output logic [DATA_W-1:0] o_cmp,
  output logic [DATA_W-1:0] o_status,
  output logic              o_irq
);

  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0] c_PRESC_MAX = PW'(PRESC - 1);

  logic [PW-1:0]     r_presc;
  logic [DATA_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_cmp;
  logic              r_flag;
  logic              r_en;

  logic w_tick;
  logic w_match;
  logic w_wr_cnt;
  logic w_wr_cmp;
  logic w_wr_stat;

  assign w_tick    = r_en && (r_presc == c_PRESC_MAX);
  assign w_match   = w_tick && (r_cnt == r_cmp);
  assign w_wr_cnt  = i_we && (i_sel == SEL_CNT);
  assign w_wr_cmp  = i_we && (i_sel == SEL_CMP);
  assign w_wr_stat = i_we && (i_sel == SEL_STAT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
      r_cnt   <= '0;
      r_cmp   <= '1;
      r_flag  <= 1'b0;
      r_en    <= 1'b0;
    end else begin
      if (r_en) begin
        r_presc <= w_tick ? '0 : r_presc + 1'b1;
      end

      // A core write to CNT overrides the tick increment; the prescaler has
      // already wrapped on that edge so the next period starts fresh.
      if (w_wr_cnt) begin
        r_cnt <= i_wdata;
      end else if (w_tick) begin
        r_cnt <= w_match ? '0 : r_cnt + 1'b1;
      end

      if (w_wr_cmp) begin
        r_cmp <= i_wdata;
      end

      // Set dominates a simultaneous write-1-to-clear so no match is lost.
      if (w_match) begin
        r_flag <= 1'b1;
      end else if (w_wr_stat && i_wdata[ST_FLAG]) begin
        r_flag <= 1'b0;
      end

      if (w_wr_stat) begin
        r_en <= i_wdata[ST_EN];
      end
    end
  end

  always_comb begin
    o_status          = '0;
    o_status[ST_FLAG] = r_flag;
    o_status[ST_EN]   = r_en;
  end

  assign o_cnt = r_cnt;
  assign o_cmp = r_cmp;
  assign o_irq = r_flag;

endmodule
`default_nettype wire

// File: rtl/poco_dmem.sv
`default_nettype none
// ============================================================================
// Module      : poco_dmem
// Description : POCO data-port responder: word RAM plus OUT/IN/timer I/O page
// Revision    : 1.0  initial release
// ============================================================================
module poco_dmem #(
  parameter int DATA_W = poco_dmem_pkg::DATA_W,
  parameter int RAM_AW = 8,
  parameter int PRESC  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] daddr,
  input  logic [DATA_W-1:0] ddataout,
  input  logic              we,
  output logic [DATA_W-1:0] ddatain,
  output logic [DATA_W-1:0] out_port,
  input  logic [DATA_W-1:0] in_port,
  output logic              tmr_irq
);

  import poco_dmem_pkg::*;

  localparam int RAM_WORDS = 2 ** RAM_AW;

  logic [DATA_W-1:0] r_ram [RAM_WORDS];
  logic [DATA_W-1:0] r_out;
  logic [DATA_W-1:0] r_in_s1;
  logic [DATA_W-1:0] r_in_s2;

  io_sel_e           w_sel;
  logic [DATA_W-1:0] w_cnt;
  logic [DATA_W-1:0] w_cmp;
  logic [DATA_W-1:0] w_status;
  logic              w_irq;

  assign w_sel = decode(daddr, RAM_AW);

  // RAM carries no reset so it survives a mid-run rst pulse.
  always_ff @(posedge clk) begin
    if (we && (w_sel == SEL_RAM)) begin
      r_ram[daddr[RAM_AW-1:0]] <= ddataout;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out   <= '0;
      r_in_s1 <= '0;
      r_in_s2 <= '0;
    end else begin
      r_in_s1 <= in_port;
      r_in_s2 <= r_in_s1;
      if (we && (w_sel == SEL_OUT)) begin
        r_out <= ddataout;
      end
    end
  end

  poco_timer #(
    .PRESC (PRESC)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_we     (we),
    .i_sel    (w_sel),
    .i_wdata  (ddataout),
    .o_cnt    (w_cnt),
    .o_cmp    (w_cmp),
    .o_status (w_status),
    .o_irq    (w_irq)
  );

  always_comb begin
    ddatain = '0;
    case (w_sel)
      SEL_RAM:  ddatain = r_ram[daddr[RAM_AW-1:0]];
      SEL_OUT:  ddatain = r_out;
      SEL_IN:   ddatain = r_in_s2;
      SEL_CNT:  ddatain = w_cnt;
      SEL_CMP:  ddatain = w_cmp;
      SEL_STAT: ddatain = w_status;
      default:  ddatain = '0;
    endcase
  end

  assign out_port = r_out;
  assign tmr_irq  = w_irq;

endmodule
`default_nettype wire

// File: tb/tb_poco_dmem.sv
`default_nettype none
// ============================================================================
// Module      : tb_poco_dmem
// Description : Directed self-checking bench for poco_dmem with a memory-map model
// Revision    : 1.0  initial release
// ============================================================================
module tb_poco_dmem;

  localparam int PRESC  = 4;
  localparam int RAM_AW = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] daddr = '0;
  logic [15:0] ddataout = '0;
  logic        we = 1'b0;
  logic [15:0] ddatain;
  logic [15:0] out_port;
  logic [15:0] in_port = '0;
  logic        tmr_irq;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  poco_dmem #(
    .DATA_W (16),
    .RAM_AW (RAM_AW),
    .PRESC  (PRESC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .daddr    (daddr),
    .ddataout (ddataout),
    .we       (we),
    .ddatain  (ddatain),
    .out_port (out_port),
    .in_port  (in_port),
    .tmr_irq  (tmr_irq)
  );

  // Reference model of the memory map
  logic [15:0] m_ram [int];
  logic [15:0] m_out  = '0;
  logic [15:0] m_in1  = '0;
  logic [15:0] m_in2  = '0;
  logic [15:0] m_cnt  = '0;
  logic [15:0] m_cmp  = 16'hFFFF;
  logic        m_flag = 1'b0;
  logic        m_en   = 1'b0;
  int          m_ecyc = 0;

  function automatic bit m_tick_next();
    return m_en && ((m_ecyc % PRESC) == PRESC - 1);
  endfunction

  function automatic bit m_match_next();
    return m_tick_next() && (m_cnt == m_cmp);
  endfunction

  // bit 16 = value is defined
  function automatic logic [16:0] m_read(input logic [15:0] a);
    if (int'(a) < (1 << RAM_AW)) begin
      if (m_ram.exists(int'(a))) return {1'b1, m_ram[int'(a)]};
      return 17'h0;
    end
    case (a)
      16'hFFF0: return {1'b1, m_out};
      16'hFFF1: return {1'b1, m_in2};
      16'hFFF2: return {1'b1, m_cnt};
      16'hFFF3: return {1'b1, m_cmp};
      16'hFFF4: return {1'b1, 14'd0, m_en, m_flag};
      default:  return {1'b1, 16'h0000};
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_out = '0; m_in1 = '0; m_in2 = '0; m_cnt = '0; m_cmp = 16'hFFFF;
      m_flag = 1'b0; m_en = 1'b0; m_ecyc = 0;
    end else begin
      bit tick, match;
      tick  = m_tick_next();
      match = m_match_next();
      m_in2 = m_in1;
      m_in1 = in_port;
      if (m_en) m_ecyc = tick ? 0 : m_ecyc + 1;
      if (tick) m_cnt = match ? 16'h0 : 16'((int'(m_cnt) + 1) % 65536);
      if (match) m_flag = 1'b1;
      if (we) begin
        if (int'(daddr) < (1 << RAM_AW)) m_ram[int'(daddr)] = ddataout;
        else begin
          case (daddr)
            16'hFFF0: m_out = ddataout;
            16'hFFF2: m_cnt = ddataout;
            16'hFFF3: m_cmp = ddataout;
            16'hFFF4: begin
              if (ddataout[0] && !match) m_flag = 1'b0;
              m_en = ddataout[1];
            end
            default: ;
          endcase
        end
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [16:0] r;
    r = m_read(daddr);
    if (r[16]) chk("model_ddatain", ddatain, r[15:0]);
    chk("model_out_port", out_port, m_out);
    chk("model_tmr_irq", {15'd0, tmr_irq}, {15'd0, m_flag});
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    daddr = a; ddataout = d; we = 1'b1;
    step(1);
    we = 1'b0;
  endtask

  task automatic rdc(input string name, input logic [15:0] a, input logic [15:0] exp);
    daddr = a; we = 1'b0;
    #1;
    chk(name, ddatain, exp);
  endtask

  task automatic wait_model(input bit want_match);
    int n = 0;
    while (!(want_match ? m_match_next() : m_tick_next()) && n < 64) begin
      step(1);
      n++;
    end
    chk("wait_bound", {15'd0, n < 64}, 16'd1);
  endtask

  initial begin
    step(2);
    rst = 1'b0;

    // Reset values
    rdc("rst_out",  16'hFFF0, 16'h0000);
    rdc("rst_cnt",  16'hFFF2, 16'h0000);
    rdc("rst_cmp",  16'hFFF3, 16'hFFFF);
    rdc("rst_stat", 16'hFFF4, 16'h0000);
    rdc("rst_none", 16'h1234, 16'h0000);
    chk("rst_irq", {15'd0, tmr_irq}, 16'd0);

    // RAM
    wr(16'h0005, 16'hBEEF);
    daddr = 16'h0005; ddataout = 16'h1234; we = 1'b1;
    #1;
    chk("ram_read_during_write", ddatain, 16'hBEEF);
    step(1);
    we = 1'b0;
    rdc("ram_new", 16'h0005, 16'h1234);
    wr(16'h0005, 16'hBEEF);
    wr(16'h00FF, 16'h1111);
    rdc("ram_5",  16'h0005, 16'hBEEF);
    rdc("ram_ff", 16'h00FF, 16'h1111);
    wr(16'h0000, 16'h5A5A);
    wr(16'h0100, 16'hDEAD);
    rdc("ram_no_alias", 16'h0000, 16'h5A5A);
    rdc("ram_above",    16'h0100, 16'h0000);

    // Output and synchronised input ports
    wr(16'hFFF0, 16'hA5A5);
    chk("out_port", out_port, 16'hA5A5);
    rdc("out_rd", 16'hFFF0, 16'hA5A5);
    in_port = 16'h0F0F;
    rdc("in_edge0", 16'hFFF1, 16'h0000);
    step(1);
    rdc("in_edge1", 16'hFFF1, 16'h0000);
    step(1);
    rdc("in_edge2", 16'hFFF1, 16'h0F0F);
    wr(16'hFFF1, 16'h1111);
    rdc("in_ro", 16'hFFF1, 16'h0F0F);

    // Timer counting and first match
    wr(16'hFFF3, 16'h0003);
    wr(16'hFFF4, 16'h0002);
    daddr = 16'hFFF2;
    for (int i = 1; i <= 16; i++) begin
      step(1);
      if (i == 3)  rdc("tmr_c3",  16'hFFF2, 16'h0000);
      if (i == 4)  rdc("tmr_c4",  16'hFFF2, 16'h0001);
      if (i == 8)  rdc("tmr_c8",  16'hFFF2, 16'h0002);
      if (i == 12) rdc("tmr_c12", 16'hFFF2, 16'h0003);
      if (i == 15) chk("tmr_irq_c15", {15'd0, tmr_irq}, 16'd0);
    end
    rdc("tmr_c16", 16'hFFF2, 16'h0000);
    chk("tmr_irq_c16", {15'd0, tmr_irq}, 16'd1);
    rdc("tmr_stat", 16'hFFF4, 16'h0003);

    // Clear flag, then W1C on the exact match edge
    wr(16'hFFF4, 16'h0003);
    rdc("w1c_stat", 16'hFFF4, 16'h0002);
    chk("w1c_irq", {15'd0, tmr_irq}, 16'd0);
    wait_model(1'b1);
    wr(16'hFFF4, 16'h0003);
    rdc("w1c_collide_stat", 16'hFFF4, 16'h0003);
    rdc("w1c_collide_cnt",  16'hFFF2, 16'h0000);

    // CNT write on a tick edge
    wait_model(1'b0);
    wr(16'hFFF2, 16'h0002);
    rdc("cntwr_val", 16'hFFF2, 16'h0002);
    step(3);
    rdc("cntwr_hold", 16'hFFF2, 16'h0002);
    step(1);
    rdc("cntwr_tick", 16'hFFF2, 16'h0003);

    // 16-bit wrap with CMP at full scale
    wr(16'hFFF4, 16'h0001);
    wr(16'hFFF3, 16'hFFFF);
    wr(16'hFFF2, 16'hFFFE);
    rdc("wrap_stat_off", 16'hFFF4, 16'h0000);
    wr(16'hFFF4, 16'h0002);
    daddr = 16'hFFF2;
    step(3);
    rdc("wrap_ffff", 16'hFFF2, 16'hFFFF);
    step(3);
    rdc("wrap_hold", 16'hFFF2, 16'hFFFF);
    chk("wrap_irq0", {15'd0, tmr_irq}, 16'd0);
    step(1);
    rdc("wrap_zero", 16'hFFF2, 16'h0000);
    chk("wrap_irq1", {15'd0, tmr_irq}, 16'd1);

    // Asynchronous reset mid-count
    step(2);
    rst = 1'b1;
    #1;
    rdc("arst_cnt", 16'hFFF2, 16'h0000);
    rdc("arst_stat", 16'hFFF4, 16'h0000);
    chk("arst_out", out_port, 16'h0000);
    chk("arst_irq", {15'd0, tmr_irq}, 16'd0);
    rdc("arst_ram", 16'h0005, 16'hBEEF);
    step(1);
    rst = 1'b0;
    step(2);
    rdc("post_rst_ram", 16'h00FF, 16'h1111);
    rdc("post_rst_cnt", 16'hFFF2, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
